// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg
//   Shared definitions for the register-file write arbiter slice:
//   default data/address widths, the port-select encoding used by the
//   round-robin arbiter, and the hard-wired zero register index.
//   Optional feature macro used elsewhere in this slice: REGWR_BYPASS_EN.
package regfile_write_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 reads as zero, so writes to it are swallowed.
  localparam int REG_ZERO = 0;

  // Identifies which writeback requester owns the write port.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Writeback request bus carrying both requesters into the arbiter.
//   Port A is ALU writeback, port B is load writeback.
//     a_valid/a_addr/a_data, b_valid/b_addr/b_data : request from requester
//     a_ready/b_ready                               : accept back to requester
//   Modports: master = the execute/memory stages, slave = the arbiter.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;

  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;

  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    output a_ready, b_ready
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// regfile_write_arbiter_rr_arb2 (the rr_arb2 round-robin arbiter)
//   Two-requester round-robin arbiter.
//     clk, reset : clock and synchronous active-high reset
//     req[1:0]   : request vector, bit 0 = port A, bit 1 = port B
//     gnt[1:0]   : one-hot grant, all zero while reset is high
//   The last-grant register only moves on a conflict cycle, so an
//   uncontested requester never steals priority from the other one.
module regfile_write_arbiter_rr_arb2
  import regfile_write_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  port_sel_t last_q;

  // Grant decision: a lone requester wins outright; on a conflict the
  // requester that did not win the previous conflict is chosen.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt = (last_q == PORT_B) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the conflict winner. Reset leaves B as last winner so that
  // A is favoured on the first conflict.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_B;
    end else if (req == 2'b11) begin
      last_q <= gnt[1] ? PORT_B : PORT_A;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between ALU writeback
//   (port A) and load writeback (port B), and keeps a busy scoreboard of
//   outstanding destinations so decode can stall on RAW hazards.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     wr (slave)          : writeback request bus from both requesters
//     iss_valid, iss_addr : decode issues an instruction with a destination
//     rd_addr1, rd_addr2  : decode source registers
//     hazard              : a source register has a pending write
//     flush               : clear all scoreboard entries
//     RegWrite, inC, out  : registered register-file write port
//   Optional feature macro REGWR_BYPASS_EN adds fwd1_hit, fwd2_hit and
//   fwd_data, and lets forwarded sources drop out of the hazard term.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  regfile_write_arbiter_if.slave wr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              hazard,
  input  logic              flush,
`ifdef REGWR_BYPASS_EN
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              RegWrite,
  output logic [ADDR_W-1:0] inC,
  output logic [DATA_W-1:0] out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [1:0]        gnt;
  logic              acc_a;
  logic              acc_b;
  logic              acc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              src1_pending;
  logic              src2_pending;

  regfile_write_arbiter_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({wr.b_valid, wr.a_valid}),
    .gnt   (gnt)
  );

  assign wr.a_ready = gnt[0];
  assign wr.b_ready = gnt[1];

  // A grant only ever goes to a valid requester, so grant implies accept.
  // The mux picks whichever side was accepted this cycle.
  always_comb begin
    acc_a    = wr.a_valid & gnt[0];
    acc_b    = wr.b_valid & gnt[1];
    acc      = acc_a | acc_b;
    sel_addr = acc_b ? wr.b_addr : wr.a_addr;
    sel_data = acc_b ? wr.b_data : wr.a_data;
  end

  // Write stage: one cycle after acceptance the register file sees the
  // write. Writes to register 0 are accepted but never enabled. Address
  // and data hold when idle so the register file lines stay quiet.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite <= 1'b0;
      inC      <= '0;
      out      <= '0;
    end else begin
      RegWrite <= acc && (sel_addr != ZERO_ADDR);
      if (acc) begin
        inC <= sel_addr;
        out <= sel_data;
      end
    end
  end

  // Scoreboard next state. The clear from an accepted write is applied
  // before the issue set so a newer producer of the same register stays
  // outstanding. Flush overrides both; register 0 is never tracked.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (acc) begin
        busy_d[sel_addr] = 1'b0;
      end
      if (iss_valid) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

`ifdef REGWR_BYPASS_EN
  // A source matching the write in flight can take its value from the
  // write port instead of stalling.
  always_comb begin
    fwd1_hit = RegWrite && (inC == rd_addr1) && (rd_addr1 != ZERO_ADDR);
    fwd2_hit = RegWrite && (inC == rd_addr2) && (rd_addr2 != ZERO_ADDR);
    fwd_data = out;
  end

  assign src1_pending = busy_q[rd_addr1] & (rd_addr1 != ZERO_ADDR) & ~fwd1_hit;
  assign src2_pending = busy_q[rd_addr2] & (rd_addr2 != ZERO_ADDR) & ~fwd2_hit;
`else
  assign src1_pending = busy_q[rd_addr1] & (rd_addr1 != ZERO_ADDR);
  assign src2_pending = busy_q[rd_addr2] & (rd_addr2 != ZERO_ADDR);
`endif

  assign hazard = src1_pending | src2_pending;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback requesters: ALU writeback (port A) and load writeback (port B).
- Tracks outstanding destination registers in a 32-entry busy scoreboard. Decode uses it to stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.
- Drives the register file's write-enable, write-address and write-data lines from registers, so they are stable before the register file's negedge capture.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register address width (depth 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A write request.
- a_addr  in  ADDR_W  port A destination register.
- a_data  in  DATA_W  port A write data.
- a_ready  out  1  port A request accepted this cycle.
- b_valid  in  1  port B write request.
- b_addr  in  ADDR_W  port B destination register.
- b_data  in  DATA_W  port B write data.
- b_ready  out  1  port B request accepted this cycle.
- iss_valid  in  1  decode issues an instruction with a destination.
- iss_addr  in  ADDR_W  destination register of the issued instruction.
- rd_addr1  in  ADDR_W  decode source register 1.
- rd_addr2  in  ADDR_W  decode source register 2.
- hazard  out  1  a source register has a pending write; decode must stall.
- flush  in  1  clear all pending scoreboard entries.
- RegWrite  out  1  register-file write enable.
- inC  out  ADDR_W  register-file write address.
- out  out  DATA_W  register-file write data.

Behaviour:
- Clock and reset are fixed: single clock clk; reset is synchronous and active-high.
- Reset values:
  - RegWrite=0, inC=0, out=0.
  - busy[] all 0.
  - rr_last=B, so A has first priority after reset.
  - a_ready=0 and b_ready=0 while reset is high.
- Arbitration is combinational within the cycle:
  - Only one port valid: that port is granted.
  - Both valid: the port not equal to rr_last is granted. rr_last updates to the granted port only on a conflict cycle.
  - Ready is asserted only for the granted port. A handshake completes on valid&&ready at the rising edge.
  - A requester must hold valid, addr and data stable until ready.
- Write stage (1-cycle latency):
  - On an accepted request at rising edge N, inC/out take the granted addr/data and RegWrite=1 for cycle N+1. The register file captures at the falling edge inside N+1.
  - With no accept, RegWrite=0 at the next edge; inC and out hold their last values.
- Register 0:
  - A request with addr 0 is accepted (ready=1) but produces RegWrite=0.
  - busy[0] is never set. hazard never asserts for address 0.
- Scoreboard:
  - iss_valid sets busy[iss_addr].
  - An accepted write clears busy[addr].
  - Simultaneous set and clear of the same address: the set wins, because a newer producer is outstanding.
- hazard = busy[rd_addr1] | busy[rd_addr2]. It is combinational from registered busy only.
- flush:
  - Clears all busy bits at the edge and takes priority over an iss_valid set in the same cycle.
  - It does not cancel a write already accepted; that write still reaches the register file.
  - Grants in the flush cycle proceed normally.
- Reset asserted mid-operation discards any pending write stage: RegWrite=0 from the next edge.

Optional Feature:
- Macro: REGWR_BYPASS_EN.
- When defined:
  - Adds outputs fwd1_hit, fwd2_hit (1 bit each) and fwd_data (DATA_W).
  - fwd1_hit=RegWrite && inC==rd_addr1 && rd_addr1!=0; fwd2_hit likewise for rd_addr2. fwd_data=out.
  - hazard excludes any source that hits forwarding, including the busy bit being cleared that cycle.
- When undefined: these ports do not exist, and hazard is as described in Behaviour.

Decomposition:
- Shared package holds DATA_W and ADDR_W defaults, the port-select encoding (PORT_A=0, PORT_B=1) and the REG_ZERO constant.
- One natural sub-module: rr_arb2, a two-requester round-robin arbiter (inputs: reqs; outputs: one-hot grant; internal last-grant register).
- The scoreboard stays inline.

Test Plan:
- Reset: hold reset 2 cycles with a_valid=1 → RegWrite=0, a_ready=0, hazard=0. First cycle after reset: a_ready=1; next cycle RegWrite=1.
- Single write: a_valid, a_addr=5, a_data=0xDEADBEEF → a_ready=1 same cycle; next cycle RegWrite=1, inC=5, out=0xDEADBEEF; following cycle RegWrite=0.
- Conflict: both valid for 4 cycles (A→3, B→7) → grant order A,B,A,B; each ready single-cycle; inC sequence 3,7,3,7.
- Zero register: b_valid, b_addr=0, b_data=0x1234 → b_ready=1; RegWrite stays 0; hazard with rd_addr1=0 stays 0.
- Scoreboard: iss_valid, iss_addr=9; next cycle rd_addr2=9 → hazard=1. Write to 9 accepted → hazard=0 the cycle after. Same-cycle iss 9 and write accept 9 → busy[9] remains 1.
- Flush: busy 4 and 6 set, flush=1 with iss_valid addr 4 → all busy 0 next cycle, hazard=0 for rd 4 and 6.
